// File: rtl/pb_port_cmd_decoder.sv
// pb_port_cmd_decoder: kcpsm6 port fabric with state/GP output ports, key command pulses, reset pulse and edge interrupts
module pb_port_cmd_decoder #(
  parameter int NUM_GP = 2,
  parameter logic [7:0] GP_BASE_ID = 8'h10,
  parameter logic [7:0] CMD_PORT_ID = 8'h01,
  parameter logic [7:0] STATE_PORT_ID = 8'h02,
  parameter logic [7:0] IRQ_PORT_ID = 8'h03,
  parameter logic [7:0] STATUS_PORT_ID = 8'h04,
  parameter int NUM_IRQ = 4,
  parameter int RESET_CYCLES = 1044,
  parameter logic [7:0] KEY_UP = 8'h57,
  parameter logic [7:0] KEY_DOWN = 8'h53,
  parameter logic [7:0] KEY_LEFT = 8'h41,
  parameter logic [7:0] KEY_RIGHT = 8'h44,
  parameter logic [7:0] KEY_RESET = 8'h08,
  parameter logic [7:0] KEY_INSTR = 8'h49
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            port_id,
  input  logic [7:0]            out_port,
  input  logic                  write_strobe,
  input  logic                  k_write_strobe,
  input  logic                  read_strobe,
  output logic [7:0]            in_port,
  output logic                  interrupt,
  input  logic                  interrupt_ack,
  input  logic [NUM_IRQ-1:0]    irq_src,
  input  logic [7:0]            status_in,
  output logic [7:0]            estado_port,
  output logic [8*NUM_GP-1:0]   gp_out,
  output logic                  sumar,
  output logic                  restar,
  output logic                  izquierda,
  output logic                  derecha,
  output logic                  instrucciones,
  output logic                  reset_o
);
  localparam int CW = $clog2(RESET_CYCLES + 1);
  localparam logic [CW-1:0] RC = CW'(RESET_CYCLES);
  logic [7:0] key;
  logic [CW-1:0] cnt;
  logic [NUM_IRQ-1:0] irq_d, pending, edges, clr;
  function automatic logic hit(input logic [7:0] id);
    return (write_strobe && port_id == id) || (k_write_strobe && port_id[3:0] == id[3:0]);
  endfunction
  assign edges = irq_src & ~irq_d;
  assign clr = (read_strobe && port_id == IRQ_PORT_ID) ? in_port[NUM_IRQ-1:0] : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      key <= '0;
      cnt <= '0;
      irq_d <= '0;
      pending <= '0;
      in_port <= '0;
      interrupt <= 1'b0;
      estado_port <= '0;
      gp_out <= '0;
      sumar <= 1'b0;
      restar <= 1'b0;
      izquierda <= 1'b0;
      derecha <= 1'b0;
      instrucciones <= 1'b0;
      reset_o <= 1'b0;
    end else begin
      key <= hit(CMD_PORT_ID) ? out_port : 8'h00;
      sumar <= key == KEY_UP;
      restar <= key == KEY_DOWN;
      izquierda <= key == KEY_LEFT;
      derecha <= key == KEY_RIGHT;
      instrucciones <= instrucciones ^ (key == KEY_INSTR);
      if (cnt != '0) begin
        cnt <= cnt - CW'(1);
        reset_o <= cnt != CW'(1);
      end else if (key == KEY_RESET) begin
        cnt <= RC;
        reset_o <= 1'b1;
      end
      if (hit(STATE_PORT_ID)) estado_port <= out_port;
      for (int i = 0; i < NUM_GP; i++)
        if (hit(8'(GP_BASE_ID + i))) gp_out[8*i +: 8] <= out_port;
      irq_d <= irq_src;
      pending <= (pending & ~clr) | edges;
      interrupt <= |edges | (interrupt & ~interrupt_ack);
      in_port <= port_id == IRQ_PORT_ID ? 8'(pending) : port_id == STATUS_PORT_ID ? status_in : 8'h00;
    end
  end
endmodule

// File: tb/tb_pb_port_cmd_decoder.sv
// tb_pb_port_cmd_decoder: directed and randomized checks of pb_port_cmd_decoder against a cycle-level reference model
module tb_pb_port_cmd_decoder;
  localparam int R = 1044;
  logic clk = 0, reset = 1;
  logic [7:0] port_id = 0, out_port = 0, status_in = 0;
  logic write_strobe = 0, k_write_strobe = 0, read_strobe = 0, interrupt_ack = 0;
  logic [3:0] irq_src = 0;
  logic [7:0] in_port, estado_port;
  logic [15:0] gp_out;
  logic interrupt, sumar, restar, izquierda, derecha, instrucciones, reset_o;
  int vectors = 0, miscompares = 0;
  always #5 clk = ~clk;
  pb_port_cmd_decoder dut (
    .clk(clk), .reset(reset), .port_id(port_id), .out_port(out_port),
    .write_strobe(write_strobe), .k_write_strobe(k_write_strobe), .read_strobe(read_strobe),
    .in_port(in_port), .interrupt(interrupt), .interrupt_ack(interrupt_ack), .irq_src(irq_src),
    .status_in(status_in), .estado_port(estado_port), .gp_out(gp_out), .sumar(sumar),
    .restar(restar), .izquierda(izquierda), .derecha(derecha), .instrucciones(instrucciones),
    .reset_o(reset_o)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic bit hit(input logic [7:0] id);
    return (write_strobe && port_id == id) || (k_write_strobe && port_id[3:0] == id[3:0]);
  endfunction
  int cyc = 0, rst_end = 0, prev_cmd = -1;
  bit armed = 0;
  logic [3:0] m_src_d = 0, m_pend = 0;
  logic [7:0] m_in = 0, m_est = 0;
  logic [15:0] m_gp = 0;
  logic m_int = 0, m_su = 0, m_re = 0, m_iz = 0, m_de = 0, m_ins = 0, m_ro = 0;
  always @(posedge clk) begin
    logic [7:0] nin;
    logic [3:0] e, clr;
    armed = 1;
    if (reset) begin
      rst_end = 0; prev_cmd = -1; m_src_d = 0; m_pend = 0; m_in = 0; m_est = 0; m_gp = 0;
      m_int = 0; m_su = 0; m_re = 0; m_iz = 0; m_de = 0; m_ins = 0;
    end else begin
      if (prev_cmd == 'h08 && cyc >= rst_end) rst_end = cyc + 1 + R;
      m_su = prev_cmd == 'h57;
      m_re = prev_cmd == 'h53;
      m_iz = prev_cmd == 'h41;
      m_de = prev_cmd == 'h44;
      if (prev_cmd == 'h49) m_ins = !m_ins;
      prev_cmd = hit(8'h01) ? int'(out_port) : -1;
      if (hit(8'h02)) m_est = out_port;
      for (int k = 0; k < 2; k++) if (hit(8'h10 + k)) m_gp[8*k +: 8] = out_port;
      e = irq_src & ~m_src_d;
      m_src_d = irq_src;
      clr = (read_strobe && port_id == 8'h03) ? m_in[3:0] : 4'h0;
      nin = port_id == 8'h03 ? {4'h0, m_pend} : port_id == 8'h04 ? status_in : 8'h00;
      m_pend = (m_pend & ~clr) | e;
      m_in = nin;
      m_int = (e != 0) || (m_int && !interrupt_ack);
    end
    cyc++;
    m_ro = cyc < rst_end;
  end
  always @(negedge clk) begin
    if (armed) begin
      check("in_port", in_port, m_in);
      check("interrupt", interrupt, m_int);
      check("estado_port", estado_port, m_est);
      check("gp_out", gp_out, m_gp);
      check("sumar", sumar, m_su);
      check("restar", restar, m_re);
      check("izquierda", izquierda, m_iz);
      check("derecha", derecha, m_de);
      check("instrucciones", instrucciones, m_ins);
      check("reset_o", reset_o, m_ro);
    end
  end
  task automatic wr(input logic [7:0] id, input logic [7:0] d, input bit k);
    port_id = id;
    out_port = d;
    if (k) k_write_strobe = 1; else write_strobe = 1;
    @(negedge clk);
    write_strobe = 0;
    k_write_strobe = 0;
  endtask
  initial begin
    int w;
    logic [7:0] keys [6] = '{8'h57, 8'h53, 8'h41, 8'h44, 8'h08, 8'h49};
    repeat (3) @(negedge clk);
    reset = 0;
    check("lit_reset_state", {in_port, estado_port, gp_out, interrupt, sumar, restar, izquierda, derecha, instrucciones, reset_o}, 0);
    wr(8'h01, 8'h57, 0);
    check("lit_sumar_n1", sumar, 0);
    @(negedge clk);
    check("lit_sumar_n2", sumar, 1);
    @(negedge clk);
    check("lit_sumar_n3", sumar, 0);
    port_id = 8'h01; out_port = 8'h44; write_strobe = 1;
    @(negedge clk);
    out_port = 8'h41;
    @(negedge clk);
    write_strobe = 0;
    check("lit_derecha", {derecha, izquierda}, 2'b10);
    @(negedge clk);
    check("lit_izquierda", {derecha, izquierda}, 2'b01);
    wr(8'hF2, 8'h5A, 1);
    check("lit_estado", estado_port, 8'h5A);
    wr(8'h10, 8'h3C, 0);
    wr(8'h11, 8'hC3, 0);
    check("lit_gp", gp_out, 16'hC33C);
    irq_src = 4'h4;
    @(negedge clk);
    check("lit_irq_set", interrupt, 1);
    repeat (20) @(negedge clk);
    check("lit_irq_held", interrupt, 1);
    interrupt_ack = 1;
    @(negedge clk);
    interrupt_ack = 0;
    check("lit_irq_ack", interrupt, 0);
    port_id = 8'h03;
    @(negedge clk);
    check("lit_irq_read", in_port, 8'h04);
    read_strobe = 1;
    @(negedge clk);
    read_strobe = 0;
    @(negedge clk);
    check("lit_irq_cleared", in_port, 8'h00);
    irq_src = 4'h6;
    @(negedge clk);
    irq_src = 4'h4;
    @(negedge clk);
    irq_src = 4'h6; interrupt_ack = 1; read_strobe = 1;
    @(negedge clk);
    interrupt_ack = 0; read_strobe = 0;
    check("lit_ack_vs_edge", interrupt, 1);
    @(negedge clk);
    check("lit_set_wins", in_port, 8'h02);
    wr(8'h01, 8'h49, 0);
    @(negedge clk);
    check("lit_instr_on", instrucciones, 1);
    wr(8'h01, 8'h49, 0);
    @(negedge clk);
    check("lit_instr_off", instrucciones, 0);
    wr(8'h01, 8'h7F, 0);
    repeat (3) begin
      @(negedge clk);
      check("lit_unknown", {sumar, restar, izquierda, derecha}, 0);
    end
    wr(8'h01, 8'h08, 0);
    w = 0;
    for (int i = 0; i < 1200; i++) begin
      if (reset_o) w++;
      port_id = 8'h01; out_port = 8'h08; write_strobe = (w == 500);
      @(negedge clk);
    end
    write_strobe = 0;
    check("lit_reset_width", w, R);
    wr(8'h01, 8'h08, 0);
    repeat (300) @(negedge clk);
    check("lit_reset_mid", reset_o, 1);
    reset = 1;
    @(negedge clk);
    reset = 0;
    check("lit_reset_abort", reset_o, 0);
    for (int i = 0; i < 4000; i++) begin
      reset = $urandom_range(0, 499) == 0;
      case ($urandom_range(0, 7))
        0, 1: port_id = 8'h01;
        2: port_id = 8'h02;
        3: port_id = 8'h03;
        4: port_id = 8'h04;
        5: port_id = 8'h10 + 8'($urandom_range(0, 1));
        default: port_id = 8'($urandom);
      endcase
      out_port = $urandom_range(0, 1) ? keys[$urandom_range(0, 5)] : 8'($urandom);
      write_strobe = $urandom_range(0, 3) == 0;
      k_write_strobe = $urandom_range(0, 7) == 0;
      read_strobe = $urandom_range(0, 3) == 0;
      interrupt_ack = $urandom_range(0, 5) == 0;
      if ($urandom_range(0, 4) == 0) irq_src[$urandom_range(0, 3)] ^= 1'b1;
      status_in = 8'($urandom);
      @(negedge clk);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
